// File: rtl/johnson_pkg.sv
// johnson_pkg
//   Shared definitions for the 5-bit Johnson digit link: the ten legal
//   code words (bit4 = m1 ... bit0 = m5), the nibble that stands in for
//   an illegal code, and the deframer FSM state type.
package johnson_pkg;

  localparam logic [4:0] JC_0 = 5'b00000;
  localparam logic [4:0] JC_1 = 5'b10000;
  localparam logic [4:0] JC_2 = 5'b11000;
  localparam logic [4:0] JC_3 = 5'b11100;
  localparam logic [4:0] JC_4 = 5'b11110;
  localparam logic [4:0] JC_5 = 5'b11111;
  localparam logic [4:0] JC_6 = 5'b01111;
  localparam logic [4:0] JC_7 = 5'b00111;
  localparam logic [4:0] JC_8 = 5'b00011;
  localparam logic [4:0] JC_9 = 5'b00001;

  localparam logic [3:0] NIB_ILLEGAL = 4'hF;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/johnson_digit_dec.sv
// johnson_digit_dec
//   Purely combinational decode of one 5-bit Johnson digit to BCD.
//   Ports:
//     code_i     5-bit Johnson code, bit4 = m1 ... bit0 = m5
//     nib_o      decoded BCD digit, NIB_ILLEGAL for any non-table code
//     illegal_o  high when code_i is not one of the ten legal codes
module johnson_digit_dec
  import johnson_pkg::*;
(
  input  logic [4:0] code_i,
  output logic [3:0] nib_o,
  output logic       illegal_o
);

  // Start from "illegal" and only clear it on an exact table match, so
  // the 22 unused codes all fall through to the default.
  always_comb begin
    nib_o     = NIB_ILLEGAL;
    illegal_o = 1'b1;
    case (code_i)
      JC_0: begin nib_o = 4'd0; illegal_o = 1'b0; end
      JC_1: begin nib_o = 4'd1; illegal_o = 1'b0; end
      JC_2: begin nib_o = 4'd2; illegal_o = 1'b0; end
      JC_3: begin nib_o = 4'd3; illegal_o = 1'b0; end
      JC_4: begin nib_o = 4'd4; illegal_o = 1'b0; end
      JC_5: begin nib_o = 4'd5; illegal_o = 1'b0; end
      JC_6: begin nib_o = 4'd6; illegal_o = 1'b0; end
      JC_7: begin nib_o = 4'd7; illegal_o = 1'b0; end
      JC_8: begin nib_o = 4'd8; illegal_o = 1'b0; end
      JC_9: begin nib_o = 4'd9; illegal_o = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/johnson_bcd_deframer.sv
// johnson_bcd_deframer
//   Collects NUM_DIG Johnson-coded digits from a valid/ready stream,
//   decodes them to BCD and presents the packed word on a valid/ready
//   output. The first digit received lands in the most significant nibble.
//   Ports:
//     clk_i        rising-edge clock
//     reset        synchronous, active-high reset
//     in_valid_i   in_code_i holds a digit
//     in_ready_o   a digit can be accepted this cycle
//     in_code_i    5-bit Johnson digit
//     out_valid_o  out_word_o/out_err_o hold a complete word
//     out_ready_i  downstream accepts the word
//     out_word_o   packed BCD word, 4*NUM_DIG bits
//     out_err_o    at least one digit of the word was illegal
//     err_clr_i    clear the illegal-digit counter
//     err_cnt_o    saturating count of accepted illegal digits
module johnson_bcd_deframer
  import johnson_pkg::*;
#(
  parameter int NUM_DIG = 4,
  parameter int ERR_W   = 8
) (
  input  logic                 clk_i,
  input  logic                 reset,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [4:0]           in_code_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [4*NUM_DIG-1:0] out_word_o,
  output logic                 out_err_o,
  input  logic                 err_clr_i,
  output logic [ERR_W-1:0]     err_cnt_o
);

  localparam int WORD_W = 4 * NUM_DIG;
  localparam int CNT_W  = $clog2(NUM_DIG + 1);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NUM_DIG - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    digCnt_q, digCnt_d;
  logic [WORD_W-1:0]   word_q, word_d, shiftWord;
  logic                outErr_q, outErr_d;
  logic [ERR_W-1:0]    errCnt_q, errCnt_d;
  logic [3:0]          decNib;
  logic                decIllegal;
  logic                accept;

  johnson_digit_dec uDec (
    .code_i    (in_code_i),
    .nib_o     (decNib),
    .illegal_o (decIllegal)
  );

  // A single-digit word has no older nibbles to keep, so the shift
  // degenerates to a plain load.
  generate
    if (NUM_DIG == 1) begin : gSingle
      assign shiftWord = decNib;
    end else begin : gMulti
      assign shiftWord = {word_q[WORD_W-5:0], decNib};
    end
  endgenerate

  // Ready is held low during reset so nothing is handshaken into a
  // block that is about to be cleared.
  always_comb begin
    in_ready_o = (state_q == COLLECT) && !reset;
    accept     = in_valid_i && in_ready_o;
  end

  // Next-state and datapath: shift digits in while collecting, park the
  // finished word in HOLD until the consumer takes it.
  always_comb begin
    state_d  = state_q;
    digCnt_d = digCnt_q;
    word_d   = word_q;
    outErr_d = outErr_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          word_d   = shiftWord;
          // The first digit of a new word restarts the error flag.
          outErr_d = (digCnt_q == '0) ? decIllegal : (outErr_q | decIllegal);
          if (digCnt_q == LAST_DIG) begin
            digCnt_d = '0;
            state_d  = HOLD;
          end else begin
            digCnt_d = digCnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Error counter: a clear wins, but an illegal digit arriving in the
  // same cycle is still counted so it is not lost.
  always_comb begin
    errCnt_d = errCnt_q;
    if (err_clr_i) begin
      errCnt_d = (accept && decIllegal) ? ERR_W'(1) : '0;
    end else if (accept && decIllegal && (errCnt_q != ERR_MAX)) begin
      errCnt_d = errCnt_q + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; a partially collected word is dropped on reset.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      digCnt_q <= '0;
      word_q   <= '0;
      outErr_q <= 1'b0;
      errCnt_q <= '0;
    end else begin
      digCnt_q <= digCnt_d;
      word_q   <= word_d;
      outErr_q <= outErr_d;
      errCnt_q <= errCnt_d;
    end
  end

  assign out_valid_o = (state_q == HOLD);
  assign out_word_o  = word_q;
  assign out_err_o   = outErr_q;
  assign err_cnt_o   = errCnt_q;

endmodule

// File: tb/tb_johnson_bcd_deframer.sv
// tb_johnson_bcd_deframer
//   Directed bench for johnson_bcd_deframer. Three instances share clock
//   and reset: a 4-digit word deframer, a 1-digit deframer for the full
//   code sweep, and a 1-digit deframer with a 2-bit error counter.
module tb_johnson_bcd_deframer;

  logic clk = 1'b0;
  logic reset;

  // 4-digit instance
  logic        iv4, ir4, ov4, or4, oe4, clr4;
  logic [4:0]  ic4;
  logic [15:0] ow4;
  logic [7:0]  ecnt4;

  // 1-digit instance
  logic        iv1, ir1, ov1, or1, oe1, clr1;
  logic [4:0]  ic1;
  logic [3:0]  ow1;
  logic [7:0]  ecnt1;

  // 1-digit instance, 2-bit error counter
  logic        ivE, irE, ovE, orE, oeE, clrE;
  logic [4:0]  icE;
  logic [3:0]  owE;
  logic [1:0]  ecntE;

  int total = 0;
  int bad   = 0;
  int illegalSeen;

  always #5 clk = ~clk;

  johnson_bcd_deframer #(.NUM_DIG(4), .ERR_W(8)) dut4 (
    .clk_i(clk), .reset(reset), .in_valid_i(iv4), .in_ready_o(ir4),
    .in_code_i(ic4), .out_valid_o(ov4), .out_ready_i(or4),
    .out_word_o(ow4), .out_err_o(oe4), .err_clr_i(clr4), .err_cnt_o(ecnt4)
  );

  johnson_bcd_deframer #(.NUM_DIG(1), .ERR_W(8)) dut1 (
    .clk_i(clk), .reset(reset), .in_valid_i(iv1), .in_ready_o(ir1),
    .in_code_i(ic1), .out_valid_o(ov1), .out_ready_i(or1),
    .out_word_o(ow1), .out_err_o(oe1), .err_clr_i(clr1), .err_cnt_o(ecnt1)
  );

  johnson_bcd_deframer #(.NUM_DIG(1), .ERR_W(2)) dutE (
    .clk_i(clk), .reset(reset), .in_valid_i(ivE), .in_ready_o(irE),
    .in_code_i(icE), .out_valid_o(ovE), .out_ready_i(orE),
    .out_word_o(owE), .out_err_o(oeE), .err_clr_i(clrE), .err_cnt_o(ecntE)
  );

  // Hand-written decode table used as the reference for the sweep.
  function automatic logic [3:0] refDecode(input logic [4:0] c);
    case (c)
      5'b00000: return 4'd0;
      5'b10000: return 4'd1;
      5'b11000: return 4'd2;
      5'b11100: return 4'd3;
      5'b11110: return 4'd4;
      5'b11111: return 4'd5;
      5'b01111: return 4'd6;
      5'b00111: return 4'd7;
      5'b00011: return 4'd8;
      5'b00001: return 4'd9;
      default:  return 4'hF;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One digit per call into the 4-digit instance.
  task automatic applyStimulus(input logic [4:0] code);
    iv4 = 1'b1;
    ic4 = code;
    tick();
  endtask

  task automatic sendWord4(input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] c, input logic [4:0] d);
    applyStimulus(a);
    applyStimulus(b);
    applyStimulus(c);
    applyStimulus(d);
    iv4 = 1'b0;
  endtask

  task automatic drainWord4();
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    iv4 = 0; ic4 = 0; or4 = 0; clr4 = 0;
    iv1 = 0; ic1 = 0; or1 = 1; clr1 = 0;
    ivE = 0; icE = 0; orE = 1; clrE = 0;
    illegalSeen = 0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_in_ready", 32'(ir4), 32'd0);
    checkOutput("rst_out_valid", 32'(ov4), 32'd0);
    checkOutput("rst_out_word", 32'(ow4), 32'd0);
    checkOutput("rst_err_cnt", 32'(ecnt4), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("post_rst_in_ready", 32'(ir4), 32'd1);

    // 1: full sweep on the single-digit instance
    for (int c = 0; c < 32; c++) begin
      iv1 = 1'b1;
      ic1 = 5'(c);
      tick();
      iv1 = 1'b0;
      if (refDecode(5'(c)) == 4'hF) illegalSeen++;
      checkOutput($sformatf("t1_valid_%0d", c), 32'(ov1), 32'd1);
      checkOutput($sformatf("t1_word_%0d", c), 32'(ow1), 32'(refDecode(5'(c))));
      checkOutput($sformatf("t1_err_%0d", c), 32'(oe1), 32'(refDecode(5'(c)) == 4'hF));
      tick();
    end
    checkOutput("t1_illegal_total", 32'(illegalSeen), 32'd22);
    checkOutput("t1_err_cnt", 32'(ecnt1), 32'd22);
    checkOutput("t1_in_ready", 32'(ir1), 32'd1);

    // 2: 1,2,3,4
    sendWord4(5'b10000, 5'b11000, 5'b11100, 5'b11110);
    checkOutput("t2_valid", 32'(ov4), 32'd1);
    checkOutput("t2_word", 32'(ow4), 32'h1234);
    checkOutput("t2_err", 32'(oe4), 32'd0);
    checkOutput("t2_in_ready", 32'(ir4), 32'd0);
    drainWord4();
    checkOutput("t2_valid_after", 32'(ov4), 32'd0);
    checkOutput("t2_ready_after", 32'(ir4), 32'd1);

    // 3: 5,illegal,9,0 then a clean word
    sendWord4(5'b11111, 5'b10100, 5'b00001, 5'b00000);
    checkOutput("t3_word", 32'(ow4), 32'h5F90);
    checkOutput("t3_err", 32'(oe4), 32'd1);
    checkOutput("t3_err_cnt", 32'(ecnt4), 32'd1);
    drainWord4();
    checkOutput("t3_err_held", 32'(oe4), 32'd1);
    sendWord4(5'b01111, 5'b00111, 5'b00011, 5'b00001);
    checkOutput("t3_word2", 32'(ow4), 32'h6789);
    checkOutput("t3_err2", 32'(oe4), 32'd0);
    checkOutput("t3_err_cnt2", 32'(ecnt4), 32'd1);
    drainWord4();

    // 4: backpressure with in_valid held high on a 7
    sendWord4(5'b10000, 5'b11000, 5'b11100, 5'b11110);
    iv4 = 1'b1;
    ic4 = 5'b00111;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("t4_hold_word_%0d", i), 32'(ow4), 32'h1234);
      checkOutput($sformatf("t4_hold_valid_%0d", i), 32'(ov4), 32'd1);
      checkOutput($sformatf("t4_hold_ready_%0d", i), 32'(ir4), 32'd0);
    end
    or4 = 1'b1;
    tick();
    checkOutput("t4_taken_valid", 32'(ov4), 32'd0);
    checkOutput("t4_resume_ready", 32'(ir4), 32'd1);
    tick();
    tick();
    tick();
    tick();
    iv4 = 1'b0;
    checkOutput("t4_next_valid", 32'(ov4), 32'd1);
    checkOutput("t4_next_word", 32'(ow4), 32'h7777);
    tick();
    or4 = 1'b0;
    checkOutput("t4_next_taken", 32'(ov4), 32'd0);

    // 5: reset mid-word, then 9,8,7,6
    applyStimulus(5'b10000);
    applyStimulus(5'b11000);
    iv4 = 1'b0;
    reset = 1'b1;
    tick();
    checkOutput("t5_rst_valid", 32'(ov4), 32'd0);
    checkOutput("t5_rst_word", 32'(ow4), 32'd0);
    checkOutput("t5_rst_err", 32'(oe4), 32'd0);
    checkOutput("t5_rst_err_cnt", 32'(ecnt4), 32'd0);
    checkOutput("t5_rst_ready", 32'(ir4), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("t5_ready", 32'(ir4), 32'd1);
    sendWord4(5'b00001, 5'b00011, 5'b00111, 5'b01111);
    checkOutput("t5_valid", 32'(ov4), 32'd1);
    checkOutput("t5_word", 32'(ow4), 32'h9876);
    checkOutput("t5_err", 32'(oe4), 32'd0);
    drainWord4();

    // 6: saturation of a 2-bit counter, then clear with a same-cycle illegal
    for (int i = 0; i < 5; i++) begin
      ivE = 1'b1;
      icE = 5'b10100;
      tick();
      ivE = 1'b0;
      checkOutput($sformatf("t6_valid_%0d", i), 32'(ovE), 32'd1);
      checkOutput($sformatf("t6_cnt_%0d", i), 32'(ecntE), (i < 3) ? 32'(i + 1) : 32'd3);
      tick();
    end
    checkOutput("t6_word", 32'(owE), 32'hF);
    checkOutput("t6_err", 32'(oeE), 32'd1);
    checkOutput("t6_ready", 32'(irE), 32'd1);
    ivE = 1'b1;
    icE = 5'b01010;
    clrE = 1'b1;
    tick();
    ivE = 1'b0;
    clrE = 1'b0;
    checkOutput("t6_clr_with_illegal", 32'(ecntE), 32'd1);
    tick();
    clrE = 1'b1;
    tick();
    clrE = 1'b0;
    checkOutput("t6_clr_only", 32'(ecntE), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
